// File: rtl/tlb_miss_walker.sv
// TLB miss walker: refills a 4-entry direct-mapped TLB from a single-level page table.
// On an accepted miss it reads one PTE from memory. It then either issues a one-cycle TLB
// write or reports a one-cycle fault: VPN out of range, PTE invalid, or read timeout.
//
// Ports:
//   i_clk, i_reset        clock; asynchronous active-high reset
//   i_miss_valid/i_miss_va, o_miss_ready    miss request handshake
//   o_mem_req/o_mem_addr, i_mem_ack/i_mem_rdata    PTE read port
//   o_write_en/o_write_va/o_write_pa       TLB write port
//   o_walk_done, o_walk_fault/o_fault_cause     walk completion status
module tlb_miss_walker #(
    parameter logic [19:0] PT_BASE       = 20'h10000,
    parameter int unsigned PT_INDEX_BITS = 8,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_miss_valid,
    input  logic [31:0] i_miss_va,
    output logic        o_miss_ready,
    output logic        o_mem_req,
    output logic [19:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_write_en,
    output logic [31:0] o_write_va,
    output logic [31:0] o_write_pa,
    output logic        o_walk_done,
    output logic        o_walk_fault,
    output logic [1:0]  o_fault_cause
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CauseRange   = 2'b01;
    localparam logic [1:0] CauseInvalid = 2'b10;
    localparam logic [1:0] CauseTimeout = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StFill, StFault} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [31:0]     r_va;
    logic [7:0]      r_ppn;
    logic [1:0]      r_cause;
    logic [1:0]      w_cause_next;
    logic [CntW-1:0] r_cnt;

    logic [19:0]     w_vpn;
    logic            w_oor;
    logic [19:0]     w_pte_off;
    logic            w_unused_rdata;

    // Any VPN bit above the table's index range means there is no PTE to fetch.
    assign w_vpn = i_miss_va[31:12];
    assign w_oor = (w_vpn >> PT_INDEX_BITS) != '0;

    assign w_pte_off = {{(18 - PT_INDEX_BITS){1'b0}}, r_va[12+PT_INDEX_BITS-1:12], 2'b00};

    // Only the valid bit and PPN of the PTE are meaningful.
    assign w_unused_rdata = ^i_mem_rdata[30:8];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_va    <= '0;
            r_ppn   <= '0;
            r_cause <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
            if (r_state == StIdle && i_miss_valid) begin
                r_va  <= i_miss_va;
                r_cnt <= '0;
            end
            if (r_state == StReq) begin
                r_cnt <= r_cnt + CntW'(1);
                if (i_mem_ack) begin
                    r_ppn <= i_mem_rdata[7:0];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        unique case (r_state)
            StIdle: begin
                if (i_miss_valid) begin
                    if (w_oor) begin
                        w_state_next = StFault;
                        w_cause_next = CauseRange;
                    end else begin
                        w_state_next = StReq;
                    end
                end
            end
            StReq: begin
                // An ack in the final allowed cycle takes priority over the timeout.
                if (i_mem_ack) begin
                    if (i_mem_rdata[31]) begin
                        w_state_next = StFill;
                    end else begin
                        w_state_next = StFault;
                        w_cause_next = CauseInvalid;
                    end
                end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                    w_state_next = StFault;
                    w_cause_next = CauseTimeout;
                end
            end
            StFill:  w_state_next = StIdle;
            StFault: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs depend on state and registers only, so reset clears them immediately.
    always_comb begin
        o_miss_ready  = (r_state == StIdle);
        o_mem_req     = (r_state == StReq);
        o_mem_addr    = (r_state == StReq) ? (PT_BASE + w_pte_off) : '0;
        o_write_en    = (r_state == StFill);
        o_walk_done   = (r_state == StFill);
        o_walk_fault  = (r_state == StFault);
        o_fault_cause = (r_state == StFault) ? r_cause : '0;
        o_write_va    = (r_state == StFill || r_state == StFault) ? r_va : '0;
        o_write_pa    = (r_state == StFill) ? {12'b0, r_ppn, r_va[11:0]} : '0;
    end

endmodule

// File: tb/tb_tlb_miss_walker.sv
module tb_tlb_miss_walker;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_miss_valid;
    logic [31:0] i_miss_va;
    logic        o_miss_ready;
    logic        o_mem_req;
    logic [19:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_write_en;
    logic [31:0] o_write_va;
    logic [31:0] o_write_pa;
    logic        o_walk_done;
    logic        o_walk_fault;
    logic [1:0]  o_fault_cause;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    tlb_miss_walker dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_miss_valid  (i_miss_valid),
        .i_miss_va     (i_miss_va),
        .o_miss_ready  (o_miss_ready),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_write_en    (o_write_en),
        .o_write_va    (o_write_va),
        .o_write_pa    (o_write_pa),
        .o_walk_done   (o_walk_done),
        .o_walk_fault  (o_walk_fault),
        .o_fault_cause (o_fault_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // One complete walk starting in the next cycle. ack_cyc is the cycle (counted from
    // acceptance = 0) in which mem_ack is driven; values outside 1..16 mean no ack.
    task automatic walk(input logic [31:0] va, input int ack_cyc, input logic [31:0] rdata);
        logic        oor;
        logic [19:0] exp_addr;
        int          end_cyc;
        logic        is_write;
        logic [1:0]  cause;
        logic [31:0] exp_pa;
        oor      = (va >> 20) != 0;
        exp_addr = 20'h10000 + 20'(((va >> 12) % 256) * 4);
        is_write = 1'b0;
        cause    = 2'd0;
        exp_pa   = 32'd0;
        if (oor) begin
            end_cyc = 1;
            cause   = 2'd1;
        end else if (ack_cyc >= 1 && ack_cyc <= 16) begin
            end_cyc = ack_cyc + 1;
            if (rdata[31]) begin
                is_write = 1'b1;
                exp_pa   = ((rdata & 32'hFF) << 12) | (va & 32'hFFF);
            end else begin
                cause = 2'd2;
            end
        end else begin
            end_cyc = 17;
            cause   = 2'd3;
        end

        @(negedge clk);
        chk1("ready_idle", o_miss_ready, 1'b1);
        i_miss_valid = 1'b1;
        i_miss_va    = va;
        for (int c = 1; c <= end_cyc; c++) begin
            @(negedge clk);
            i_miss_valid = 1'b0;
            i_miss_va    = $urandom;
            chk1("mem_req", o_mem_req, !oor && c < end_cyc);
            if (!oor && c < end_cyc) chk("mem_addr", 32'(o_mem_addr), 32'(exp_addr));
            chk1("ready_busy", o_miss_ready, 1'b0);
            chk1("write_en", o_write_en, is_write && c == end_cyc);
            chk1("walk_done", o_walk_done, is_write && c == end_cyc);
            chk1("walk_fault", o_walk_fault, !is_write && c == end_cyc);
            if (c == end_cyc) begin
                chk("write_va", o_write_va, va);
                if (is_write) chk("write_pa", o_write_pa, exp_pa);
                else chk("fault_cause", 32'(o_fault_cause), 32'(cause));
            end
            i_mem_ack   = (c == ack_cyc);
            i_mem_rdata = (c == ack_cyc) ? rdata : $urandom;
        end
        i_mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] va;
        i_reset      = 1'b1;
        i_miss_valid = 1'b0;
        i_miss_va    = '0;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;

        #2;
        chk1("rst_ready", o_miss_ready, 1'b1);
        chk1("rst_mem_req", o_mem_req, 1'b0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk1("rst_write_en", o_write_en, 1'b0);
        chk("rst_write_va", o_write_va, 32'd0);
        chk("rst_write_pa", o_write_pa, 32'd0);
        chk1("rst_walk_done", o_walk_done, 1'b0);
        chk1("rst_walk_fault", o_walk_fault, 1'b0);
        chk("rst_fault_cause", 32'(o_fault_cause), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        // Directed cases
        walk(32'h0000_3ABC, 1, 32'h8000_0042);
        walk(32'h0000_5123, 3, 32'h0000_0042);
        walk(32'h0010_0000, 1, 32'h8000_0001);
        walk(32'h0000_2000, 0, 32'h8000_0001);
        walk(32'h0000_2FFF, 16, 32'h8000_00AA);

        // Stray ack while idle
        @(negedge clk);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h8000_0055;
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk1("stray_write_en", o_write_en, 1'b0);
        chk1("stray_mem_req", o_mem_req, 1'b0);
        chk1("stray_fault", o_walk_fault, 1'b0);
        chk1("stray_ready", o_miss_ready, 1'b1);

        // Reset in cycle 2 of a walk
        i_miss_valid = 1'b1;
        i_miss_va    = 32'h0000_4000;
        @(negedge clk);
        i_miss_valid = 1'b0;
        @(negedge clk);
        chk1("pre_rst_mem_req", o_mem_req, 1'b1);
        #1 i_reset = 1'b1;
        #1;
        chk1("async_mem_req", o_mem_req, 1'b0);
        chk1("async_write_en", o_write_en, 1'b0);
        chk1("async_ready", o_miss_ready, 1'b1);
        @(negedge clk);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("post_rst_write_en", o_write_en, 1'b0);
            chk1("post_rst_fault", o_walk_fault, 1'b0);
            chk1("post_rst_mem_req", o_mem_req, 1'b0);
        end
        walk(32'h0000_1000, 1, 32'h8000_0007);

        // Back-to-back misses
        walk(32'h0000_A123, 2, 32'h8000_0011);
        walk(32'h0000_B456, 1, 32'h8000_0022);

        // Randomized walks
        for (int i = 0; i < 40; i++) begin
            va = $urandom;
            if ($urandom_range(1, 0) == 1) va = va & 32'h000F_FFFF;
            walk(va, int'($urandom_range(20, 0)), $urandom);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
